// File: rtl/uart_tx_result.sv
// uart_tx_result: serialises one SIZE_DATA_I-bit result word as
// SIZE_DATA_I/SIZE_DATA_O UART frames, low byte first. Each bit lasts
// OVER_SAMPLE i_stick pulses.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits of every frame.
module uart_tx_result #(
  parameter int SIZE_DATA_I = 32,
  parameter int SIZE_DATA_O = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int STOP_BITS   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stick,
  input  logic                   i_tx_en,
  input  logic                   i_valid,
  input  logic [SIZE_DATA_I-1:0] i_data,
  output logic                   o_ready,
  output logic                   o_tx_data,
  output logic                   o_tx_busy,
  output logic                   o_tx_done
);

  localparam int NUM_BYTES = SIZE_DATA_I / SIZE_DATA_O;
  localparam int TW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
  localparam int BW = (SIZE_DATA_O > 1) ? $clog2(SIZE_DATA_O) : 1;
  localparam int NW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  state_t                 state;
  logic [SIZE_DATA_I-1:0] shreg;
  logic [NW-1:0]          byte_cnt;
  logic [BW-1:0]          bit_idx;
  logic [TW-1:0]          tick;
  logic                   stop_cnt;
  logic [SIZE_DATA_O-1:0] cur_byte;
  logic [BW-1:0]          next_idx;
  logic                   bit_end;

  assign cur_byte = shreg[SIZE_DATA_O-1:0];
  assign next_idx = bit_idx + BW'(1);
  // A bit time closes on the tick that completes OVER_SAMPLE pulses.
  assign bit_end  = i_stick && (tick == TW'(OVER_SAMPLE - 1));

  // Transmit FSM; every output is registered so the line only moves on bit boundaries.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      byte_cnt  <= '0;
      bit_idx   <= '0;
      tick      <= '0;
      stop_cnt  <= 1'b0;
      o_ready   <= 1'b0;
      o_tx_data <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      // Tick counter runs only while a frame is on the line.
      if (state != IDLE && state != DONE && i_stick)
        tick <= bit_end ? '0 : tick + TW'(1);
      case (state)
        IDLE: begin
          o_ready <= i_tx_en;
          if (i_valid && o_ready) begin
            shreg     <= i_data;
            byte_cnt  <= '0;
            bit_idx   <= '0;
            tick      <= '0;
            stop_cnt  <= 1'b0;
            o_ready   <= 1'b0;
            o_tx_busy <= 1'b1;
            o_tx_data <= 1'b0;
            state     <= START;
          end
        end
        START: if (bit_end) begin
          o_tx_data <= cur_byte[0];
          bit_idx   <= '0;
          state     <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(SIZE_DATA_O - 1)) begin
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            o_tx_data <= ^cur_byte;
            state     <= PARITY;
`else
            o_tx_data <= 1'b1;
            stop_cnt  <= 1'b0;
            state     <= STOP;
`endif
          end else begin
            bit_idx   <= next_idx;
            o_tx_data <= cur_byte[next_idx];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          o_tx_data <= 1'b1;
          stop_cnt  <= 1'b0;
          state     <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            shreg    <= shreg >> SIZE_DATA_O;
            byte_cnt <= byte_cnt + NW'(1);
            if (byte_cnt == NW'(NUM_BYTES - 1)) begin
              state <= DONE;
            end else begin
              // Next frame starts immediately, no idle gap.
              o_tx_data <= 1'b0;
              state     <= START;
            end
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        DONE: begin
          o_tx_done <= 1'b1;
          o_tx_busy <= 1'b0;
          o_ready   <= i_tx_en;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
